// File: rtl/shreg_univ.sv
// Universal N-bit shift register (hold/shift/rotate/load/clear), 1-cycle latency, no backpressure;
// SHREG_BURST_EN adds a burst engine repeating one latched op cnt times with busy/done status.
module shreg_univ #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    opr,
  input  logic          sin,
  input  logic [N-1:0]  d,
  input  logic          start,
  input  logic [CW-1:0] cnt,
  output logic [N-1:0]  q,
  output logic          so_l,
  output logic          so_r,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_SHL  = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_ASR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  localparam logic [2:0] OP_ROR  = 3'd5;
  localparam logic [2:0] OP_LOAD = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  function automatic logic [N-1:0] apply_op(input logic [2:0] op, input logic [N-1:0] cur,
                                            input logic s, input logic [N-1:0] dv);
    logic [N-1:0] r;
    r = cur;
    case (op)
      OP_HOLD: r = cur;
      OP_SHL:  r = {cur[N-2:0], s};
      OP_SHR:  r = {s, cur[N-1:1]};
      OP_ASR:  r = {cur[N-1], cur[N-1:1]};
      OP_ROL:  r = {cur[N-2:0], cur[N-1]};
      OP_ROR:  r = {cur[0], cur[N-1:1]};
      OP_LOAD: r = dv;
      OP_CLR:  r = '0;
      default: r = cur;
    endcase
    return r;
  endfunction

  assign so_l = q[N-1];
  assign so_r = q[0];

`ifdef SHREG_BURST_EN
  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [2:0]    op_l;
  logic [CW-1:0] rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      op_l  <= OP_HOLD;
      rem   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // start takes priority over a direct op in the same cycle
          if (start) begin
            if (cnt != '0) begin
              op_l  <= opr;
              rem   <= cnt;
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end else if (en) begin
            q <= apply_op(opr, q, sin, d);
          end
        end
        RUN: begin
          q   <= apply_op(op_l, q, sin, d);
          rem <= rem - 1'b1;
          if (rem == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_burst_ins;
  assign unused_burst_ins = ^{start, cnt};
  assign busy = 1'b0;
  assign done = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= apply_op(opr, q, sin, d);
    end
  end
`endif

endmodule

// File: tb/tb_shreg_univ.sv
// Directed bench for shreg_univ: scoreboard of expected q/busy/done per step, checked #1 after each edge.
module tb_shreg_univ;

  localparam logic [2:0] HOLD = 3'd0, SHL = 3'd1, SHR = 3'd2, ASR = 3'd3,
                         ROL = 3'd4, ROR = 3'd5, LOAD = 3'd6, CLR = 3'd7;

  typedef struct packed {
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] opr = HOLD;
  logic       sin = 1'b0;
  logic [7:0] d = 8'h00;
  logic       start = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic [7:0] q;
  logic       so_l, so_r, busy, done;

  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];

  shreg_univ #(.N(8), .CW(4)) dut (
    .clk(clk), .rst(rst), .en(en), .opr(opr), .sin(sin), .d(d),
    .start(start), .cnt(cnt), .q(q), .so_l(so_l), .so_r(so_r),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, ".q"}, q, e.q);
    chk({tag, ".so_l"}, {7'd0, so_l}, {7'd0, e.q[7]});
    chk({tag, ".so_r"}, {7'd0, so_r}, {7'd0, e.q[0]});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, e.busy});
    chk({tag, ".done"}, {7'd0, done}, {7'd0, e.done});
  endtask

  // drive one cycle of inputs, record what must appear after the next edge, then compare
  task automatic step(input string tag, input logic e_in, input logic [2:0] o, input logic s,
                      input logic [7:0] dv, input logic st, input logic [3:0] c,
                      input logic [7:0] eq, input logic eb, input logic ed);
    exp_t x;
    en = e_in; opr = o; sin = s; d = dv; start = st; cnt = c;
    sb.push_back('{q: eq, busy: eb, done: ed});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      x = sb.pop_front();
      check_outputs(tag, x);
    end
  endtask

  initial begin
    #1;
    check_outputs("reset", '{q: 8'h00, busy: 1'b0, done: 1'b0});
    @(posedge clk); #1;
    rst = 1'b0;

    // asynchronous mid-cycle reset
    step("load_a5", 1, LOAD, 0, 8'hA5, 0, 0, 8'hA5, 0, 0);
    #2 rst = 1'b1;
    #1;
    check_outputs("async_rst", '{q: 8'h00, busy: 1'b0, done: 1'b0});
    @(posedge clk); #1;
    rst = 1'b0;
    step("post_rst", 0, HOLD, 0, 8'h00, 0, 0, 8'h00, 0, 0);

    // shifts
    step("load_b4", 1, LOAD, 0, 8'hB4, 0, 0, 8'hB4, 0, 0);
    step("asr",     1, ASR,  1, 8'h00, 0, 0, 8'hDA, 0, 0);
    step("shr_s1",  1, SHR,  1, 8'h00, 0, 0, 8'hED, 0, 0);
    step("shl_s0",  1, SHL,  0, 8'h00, 0, 0, 8'hDA, 0, 0);
    step("en0_hold",0, CLR,  1, 8'hFF, 0, 0, 8'hDA, 0, 0);

    // rotates, hold and clear
    step("load_81a",1, LOAD, 0, 8'h81, 0, 0, 8'h81, 0, 0);
    step("rol",     1, ROL,  0, 8'h00, 0, 0, 8'h03, 0, 0);
    step("load_81b",1, LOAD, 0, 8'h81, 0, 0, 8'h81, 0, 0);
    step("ror",     1, ROR,  0, 8'h00, 0, 0, 8'hC0, 0, 0);
    step("hold_op", 1, HOLD, 1, 8'h55, 0, 0, 8'hC0, 0, 0);
    step("clr",     1, CLR,  0, 8'h00, 0, 0, 8'h00, 0, 0);

`ifdef SHREG_BURST_EN
    // burst SHL x5; mid-burst start and CLR must be ignored
    step("b_load01",1, LOAD, 0, 8'h01, 0, 0, 8'h01, 0, 0);
    step("b_start", 0, SHL,  0, 8'h00, 1, 5, 8'h01, 1, 0);
    step("b_s1",    0, HOLD, 0, 8'h00, 0, 0, 8'h02, 1, 0);
    step("b_s2",    1, CLR,  0, 8'h00, 1, 3, 8'h04, 1, 0);
    step("b_s3",    0, HOLD, 0, 8'h00, 0, 0, 8'h08, 1, 0);
    step("b_s4",    0, HOLD, 0, 8'h00, 0, 0, 8'h10, 1, 0);
    step("b_s5",    0, HOLD, 0, 8'h00, 0, 0, 8'h20, 0, 1);
    // back-to-back start on the done cycle
    step("b2_start",0, ROR,  0, 8'h00, 1, 2, 8'h20, 1, 0);
    step("b2_s1",   0, HOLD, 0, 8'h00, 0, 0, 8'h10, 1, 0);
    step("b2_s2",   0, HOLD, 0, 8'h00, 0, 0, 8'h08, 0, 1);
    step("b2_idle", 0, HOLD, 0, 8'h00, 0, 0, 8'h08, 0, 0);
    // cnt=0: done pulse only
    step("c0_start",1, CLR,  0, 8'h00, 1, 0, 8'h08, 0, 1);
    step("c0_idle", 0, HOLD, 0, 8'h00, 0, 0, 8'h08, 0, 0);
    // start with en=1 LOAD: no direct load; burst LOAD samples d live
    step("se_start",1, LOAD, 0, 8'hFF, 1, 1, 8'h08, 1, 0);
    step("se_s1",   0, HOLD, 0, 8'h3C, 0, 0, 8'h3C, 0, 1);
    step("se_idle", 0, HOLD, 0, 8'h00, 0, 0, 8'h3C, 0, 0);
    // reset during a burst aborts with no done pulse
    step("ra_start",0, SHL,  1, 8'h00, 1, 3, 8'h3C, 1, 0);
    step("ra_s1",   0, HOLD, 1, 8'h00, 0, 0, 8'h79, 1, 0);
    #2 rst = 1'b1;
    #1;
    check_outputs("ra_rst", '{q: 8'h00, busy: 1'b0, done: 1'b0});
    @(posedge clk); #1;
    rst = 1'b0;
    step("ra_after1", 0, HOLD, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    step("ra_after2", 0, HOLD, 0, 8'h00, 0, 0, 8'h00, 0, 0);
`else
    // burst inputs have no effect; direct mode only
    step("m_start",  0, SHL,  1, 8'h00, 1, 3, 8'h00, 0, 0);
    step("m_hold",   0, HOLD, 1, 8'h00, 1, 3, 8'h00, 0, 0);
    step("m_load",   1, LOAD, 0, 8'h5A, 1, 3, 8'h5A, 0, 0);
    step("m_shl",    1, SHL,  1, 8'h00, 1, 3, 8'hB5, 0, 0);
    step("m_idle1",  0, HOLD, 0, 8'h00, 0, 0, 8'hB5, 0, 0);
    step("m_asr",    1, ASR,  0, 8'h00, 1, 1, 8'hDA, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
